// File: rtl/image_pipe_sink_buf_if.sv
// Stream-in / pop-out handshake bundle for the image-pipe sink buffer.
// The slave view is the buffer itself; the master view is the sender plus consumer.
interface image_pipe_sink_buf_if #(
  parameter int DW = 32
);
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_end;
  logic          in_busy;
  logic [DW-1:0] out_data;
  logic          out_end;
  logic          out_valid;
  logic          out_ready;

  modport slave (
    input  in_data, in_valid, in_end, out_ready,
    output in_busy, out_data, out_end, out_valid
  );

  modport master (
    output in_data, in_valid, in_end, out_ready,
    input  in_busy, out_data, out_end, out_valid
  );
endinterface

// File: rtl/image_pipe_sink_buf.sv
// Receive-side FWFT FIFO for the image-pipe stream with advisory busy,
// sticky drop flag and per-frame accepted-word counting.
module image_pipe_sink_buf #(
  parameter int DW          = 32,
  parameter int DEPTH       = 16,
  parameter int BUSY_MARGIN = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  image_pipe_sink_buf_if.slave       bus,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       frame_active,
  output logic                       frame_done,
  output logic [15:0]                frame_len,
  output logic                       overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic {IDLE, ACTIVE} state_t;

  logic [DW:0]   mem [DEPTH];
  logic [AW:0]   wptr, rptr;
  logic          empty, full, pop, accept;
  logic [LW-1:0] level_next;
  logic          busy_q;

  state_t        state, state_n;
  logic [15:0]   cnt, cnt_n, cnt_inc, len_n;
  logic          done_n;

  // Pointers carry an extra wrap bit so full and empty are distinguishable.
  assign empty  = (wptr == rptr);
  assign full   = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign pop    = !empty && bus.out_ready;
  assign accept = bus.in_valid && (!full || pop);

  assign level      = wptr - rptr;
  assign level_next = level + {{AW{1'b0}}, accept} - {{AW{1'b0}}, pop};

  assign bus.out_valid              = !empty;
  assign {bus.out_end, bus.out_data} = mem[rptr[AW-1:0]];
  assign bus.in_busy                = busy_q;

  always_ff @(posedge clk) begin
    if (accept) mem[wptr[AW-1:0]] <= {bus.in_end, bus.in_data};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr     <= '0;
      rptr     <= '0;
      busy_q   <= 1'b1;
      overflow <= 1'b0;
    end else begin
      if (accept) wptr <= wptr + 1'b1;
      if (pop)    rptr <= rptr + 1'b1;
      busy_q <= (level_next >= LW'(DEPTH - BUSY_MARGIN));
      if (bus.in_valid && !accept) overflow <= 1'b1;
    end
  end

  assign cnt_inc = (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;

  // Any end word closes the frame, even a dropped one; frame_len counts accepted words only.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    len_n   = frame_len;
    done_n  = 1'b0;
    if (bus.in_valid) begin
      if (bus.in_end) begin
        done_n  = 1'b1;
        state_n = IDLE;
        if (state == ACTIVE) len_n = accept ? cnt_inc : cnt;
        else                 len_n = accept ? 16'd1 : 16'd0;
      end else if (accept) begin
        if (state == IDLE) begin
          state_n = ACTIVE;
          cnt_n   = 16'd1;
        end else begin
          cnt_n = cnt_inc;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      frame_len  <= '0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      frame_len  <= len_n;
      frame_done <= done_n;
    end
  end

  assign frame_active = (state == ACTIVE);
endmodule

// File: tb/tb_image_pipe_sink_buf.sv
// Directed bench for image_pipe_sink_buf: FWFT ordering, busy threshold,
// full/overflow corners, frame tracking, async reset and pointer wrap.
module tb_image_pipe_sink_buf;
  localparam int DW = 32;
  localparam int DEPTH = 16;
  localparam int BUSY_MARGIN = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  level;
  logic        frame_active, frame_done, overflow;
  logic [15:0] frame_len;
  int          n_cmp = 0;
  int          n_err = 0;
  int          sent, popped;

  image_pipe_sink_buf_if #(.DW(DW)) bus ();

  image_pipe_sink_buf #(.DW(DW), .DEPTH(DEPTH), .BUSY_MARGIN(BUSY_MARGIN)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus.slave),
    .level        (level),
    .frame_active (frame_active),
    .frame_done   (frame_done),
    .frame_len    (frame_len),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [DW-1:0] d, input logic e);
    bus.in_valid = v;
    bus.in_data  = d;
    bus.in_end   = e;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, '0, 1'b0);
    bus.out_ready = 1'b0;
    #12;
    chk("rst_busy", bus.in_busy, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_level", level, 0);
    chk("rst_frame_active", frame_active, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_frame_len", frame_len, 0);
    chk("rst_overflow", overflow, 0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    chk("busy_after_rst", bus.in_busy, 0);

    // One 8-word frame streamed straight through
    bus.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, DW'(i), i == 7);
      tick();
      chk("f8_valid", bus.out_valid, 1);
      chk("f8_data", bus.out_data, i);
      chk("f8_end", bus.out_end, i == 7);
      chk("f8_busy", bus.in_busy, 0);
      chk("f8_level", level, 1);
      chk("f8_done", frame_done, i == 7);
    end
    chk("f8_len", frame_len, 8);
    chk("f8_active", frame_active, 0);
    drive(1'b0, '0, 1'b0);
    tick();
    chk("f8_drained", bus.out_valid, 0);
    chk("f8_done_low", frame_done, 0);

    // Fill to full with the consumer stalled
    bus.out_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, DW'(100 + i), 1'b0);
      tick();
      chk("fill_level", level, i + 1);
      chk("fill_busy", bus.in_busy, (i + 1) >= 14);
      chk("fill_ovf", overflow, 0);
    end
    chk("fill_active", frame_active, 1);
    bus.out_ready = 1'b1;
    drive(1'b1, DW'(116), 1'b0);
    tick();
    chk("fullpp_level", level, 16);
    chk("fullpp_ovf", overflow, 0);
    chk("fullpp_head", bus.out_data, 101);
    bus.out_ready = 1'b0;
    drive(1'b1, DW'(999), 1'b1);
    tick();
    chk("drop_ovf", overflow, 1);
    chk("drop_level", level, 16);
    chk("drop_done", frame_done, 1);
    chk("drop_len", frame_len, 17);
    chk("drop_active", frame_active, 0);
    drive(1'b0, '0, 1'b0);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk("drain_data", bus.out_data, 101 + i);
      chk("drain_end", bus.out_end, 0);
      tick();
    end
    chk("drain_empty", bus.out_valid, 0);
    chk("drain_busy", bus.in_busy, 0);

    // Reset in the middle of a 10-word frame
    bus.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, DW'(300 + i), 1'b0);
      tick();
    end
    drive(1'b0, '0, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_valid", bus.out_valid, 0);
    chk("mid_rst_level", level, 0);
    chk("mid_rst_active", frame_active, 0);
    chk("mid_rst_done", frame_done, 0);
    chk("mid_rst_ovf", overflow, 0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    chk("post_rst_done", frame_done, 0);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, DW'(400 + i), i == 3);
      tick();
      chk("f4_done", frame_done, i == 3);
    end
    chk("f4_len", frame_len, 4);
    drive(1'b0, '0, 1'b0);
    tick();

    // Back-to-back frames of 1, 3, 1 words
    drive(1'b1, DW'(500), 1'b1); tick();
    chk("b2b0_done", frame_done, 1);
    chk("b2b0_len", frame_len, 1);
    chk("b2b0_active", frame_active, 0);
    drive(1'b1, DW'(501), 1'b0); tick();
    chk("b2b1_done", frame_done, 0);
    chk("b2b1_active", frame_active, 1);
    drive(1'b1, DW'(502), 1'b0); tick();
    chk("b2b2_active", frame_active, 1);
    drive(1'b1, DW'(503), 1'b1); tick();
    chk("b2b3_done", frame_done, 1);
    chk("b2b3_len", frame_len, 3);
    chk("b2b3_active", frame_active, 0);
    drive(1'b1, DW'(504), 1'b1); tick();
    chk("b2b4_done", frame_done, 1);
    chk("b2b4_len", frame_len, 1);
    chk("b2b4_active", frame_active, 0);
    drive(1'b0, '0, 1'b0);
    tick();
    tick();

    // 40 words with random consumer stalls and busy honoured
    sent = 0;
    popped = 0;
    for (int c = 0; c < 800 && popped < 40; c++) begin
      bus.out_ready = 1'($urandom_range(0, 1));
      if (bus.out_valid && bus.out_ready) begin
        chk("wrap_data", bus.out_data, 1000 + popped);
        popped++;
      end
      if (sent < 40 && !bus.in_busy) begin
        drive(1'b1, DW'(1000 + sent), sent == 39);
        sent++;
      end else begin
        drive(1'b0, '0, 1'b0);
      end
      tick();
    end
    drive(1'b0, '0, 1'b0);
    chk("wrap_count", popped, 40);
    chk("wrap_ovf", overflow, 0);
    chk("wrap_len", frame_len, 40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
